dmem_arbiter: RTL

- Arbitrates the single data-memory port between the pipeline MEM stage (CPU) and a host/loader requester, e.g. a CNN weight loader or a debug DMA.
- Sits between the exmemreg outputs and datamemory.
- Drives a stall to the pipeline when the host owns the port.
- Prevents host starvation and caps locked host bursts.

---
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between the MEM stage and a host.
// Host starvation is bounded by a denial counter; locked bursts are capped.
module dmem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4,
   parameter int LOCK_MAX   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_re,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic [2:0]        cpu_func3,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              host_valid,
   output logic              host_ready,
   input  logic              host_we,
   input  logic              host_lock,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   input  logic [2:0]        host_func3,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic              mem_re,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [2:0]        mem_func3,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int LW = $clog2(LOCK_MAX);
   localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
   localparam logic [LW-1:0] LOCK_TOP   = LW'(LOCK_MAX - 1);

   typedef enum logic {ARB, LOCK} state_t;

   state_t            r_state, w_state_nxt;
   logic [SW-1:0]     r_starve, w_starve_nxt, w_starve_inc;
   logic [LW-1:0]     r_lock_cnt, w_lock_nxt;
   logic              r_cpu_pri, w_cpu_pri_nxt;
   logic              r_rvalid;
   logic [DATA_W-1:0] r_rdata;
   logic              w_cpu_req;
   logic              w_host_gnt;
   logic              w_cpu_gnt;

   assign w_cpu_req    = cpu_re | cpu_we;
   assign w_starve_inc = (r_starve == STARVE_TOP) ? r_starve
                                                  : r_starve + SW'(1);

   always_comb begin
      w_state_nxt   = r_state;
      w_starve_nxt  = r_starve;
      w_lock_nxt    = r_lock_cnt;
      w_cpu_pri_nxt = r_cpu_pri;
      w_host_gnt    = 1'b0;
      w_cpu_gnt     = 1'b0;
      cpu_stall     = 1'b0;
      if (rst) begin
         unique case (r_state)
            ARB: begin
               if (w_cpu_req && r_cpu_pri) begin
                  w_cpu_gnt     = 1'b1;
                  w_cpu_pri_nxt = 1'b0;
                  if (host_valid) w_starve_nxt = w_starve_inc;
               end else if (w_cpu_req && host_valid
                            && r_starve == STARVE_TOP) begin
                  w_host_gnt   = 1'b1;
                  cpu_stall    = 1'b1;
                  w_starve_nxt = '0;
               end else if (w_cpu_req) begin
                  w_cpu_gnt    = 1'b1;
                  w_starve_nxt = host_valid ? w_starve_inc : '0;
               end else if (host_valid) begin
                  w_host_gnt   = 1'b1;
                  w_starve_nxt = '0;
               end else begin
                  w_cpu_pri_nxt = 1'b0;
               end
               if (w_host_gnt && host_lock) begin
                  w_state_nxt = LOCK;
                  w_lock_nxt  = LW'(1);
               end
            end
            LOCK: begin
               // CPU stays frozen for the whole burst, bubbles included
               w_host_gnt = host_valid;
               cpu_stall  = w_cpu_req;
               if (host_valid) begin
                  if (!host_lock) begin
                     w_state_nxt = ARB;
                     w_lock_nxt  = '0;
                  end else if (r_lock_cnt == LOCK_TOP) begin
                     w_state_nxt   = ARB;
                     w_lock_nxt    = '0;
                     w_cpu_pri_nxt = 1'b1;
                  end else begin
                     w_lock_nxt = r_lock_cnt + LW'(1);
                  end
               end
            end
            default: w_state_nxt = ARB;
         endcase
      end
   end

   assign host_ready = w_host_gnt;
   assign mem_re     = w_host_gnt ? ~host_we : (w_cpu_gnt & cpu_re);
   assign mem_we     = w_host_gnt ?  host_we : (w_cpu_gnt & cpu_we);
   assign mem_addr   = w_host_gnt ? host_addr  : cpu_addr;
   assign mem_wdata  = w_host_gnt ? host_wdata : cpu_wdata;
   assign mem_func3  = w_host_gnt ? host_func3 : cpu_func3;
   assign cpu_rdata  = mem_rdata;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= ARB;
         r_starve   <= '0;
         r_lock_cnt <= '0;
         r_cpu_pri  <= 1'b0;
         r_rvalid   <= 1'b0;
         r_rdata    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_starve   <= w_starve_nxt;
         r_lock_cnt <= w_lock_nxt;
         r_cpu_pri  <= w_cpu_pri_nxt;
         r_rvalid   <= w_host_gnt & ~host_we;
         if (w_host_gnt && !host_we) r_rdata <= mem_rdata;
      end
   end

   assign host_rvalid = r_rvalid;
   assign host_rdata  = r_rdata;

endmodule
